// File: rtl/tc_psum_issue_pkg.sv
// Shared tensor-core definitions: issue FSM encoding and job-size helpers.
package tc_psum_issue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_OUT_REQ  = 3'd3,
        ST_WAIT_OUT = 3'd4,
        ST_FIN      = 3'd5
    } psum_state_e;

    // The accumulator's internal state trails its input by two cycles, so
    // zeros are fed for this long before real beats are issued.
    localparam int ARM_CYCLES = 2;

    // Number of partial-sum beats making up one tile job.
    function automatic int beats_per_job(input int m, input int n,
                                         input int tile_m, input int k_steps);
        return k_steps * n * (m / tile_m);
    endfunction

endpackage

// File: rtl/tc_tile_addr_gen.sv
// Nested row-group / column / k-pass counter producing accumulator addresses.
module tc_tile_addr_gen
    import tc_psum_issue_pkg::*;
#(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int TILE_M  = 4,
    parameter int K_STEPS = 4,
    parameter int DW_POS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [DW_POS-1:0] row,
    output logic [DW_POS-1:0] col,
    output logic              last
);

    localparam int RG_N  = M / TILE_M;
    localparam int BEATS = beats_per_job(M, N, TILE_M, K_STEPS);
    localparam int RG_W  = (RG_N    > 1) ? $clog2(RG_N)    : 1;
    localparam int C_W   = (N       > 1) ? $clog2(N)       : 1;
    localparam int K_W   = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
    localparam int B_W   = (BEATS   > 1) ? $clog2(BEATS)   : 1;

    localparam logic [RG_W-1:0] RG_MAX = RG_W'(RG_N - 1);
    localparam logic [C_W-1:0]  C_MAX  = C_W'(N - 1);
    localparam logic [K_W-1:0]  K_MAX  = K_W'(K_STEPS - 1);
    localparam logic [B_W-1:0]  B_MAX  = B_W'(BEATS - 1);

    logic [RG_W-1:0] rg_r;
    logic [C_W-1:0]  c_r;
    logic [K_W-1:0]  k_r;
    logic [B_W-1:0]  beat_r;

    // Row group steps fastest, then column, then k pass; all wrap to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rg_r   <= {RG_W{1'b0}};
            c_r    <= {C_W{1'b0}};
            k_r    <= {K_W{1'b0}};
            beat_r <= {B_W{1'b0}};
        end else if (advance) begin
            beat_r <= (beat_r == B_MAX) ? {B_W{1'b0}} : beat_r + B_W'(1);
            if (rg_r == RG_MAX) begin
                rg_r <= {RG_W{1'b0}};
                if (c_r == C_MAX) begin
                    c_r <= {C_W{1'b0}};
                    k_r <= (k_r == K_MAX) ? {K_W{1'b0}} : k_r + K_W'(1);
                end else begin
                    c_r <= c_r + C_W'(1);
                end
            end else begin
                rg_r <= rg_r + RG_W'(1);
            end
        end else begin
            beat_r <= beat_r;
        end
    end

    assign row  = DW_POS'(32'(rg_r) * TILE_M);
    assign col  = DW_POS'(c_r);
    assign last = (beat_r == B_MAX);

endmodule

// File: rtl/tc_psum_issue.sv
// Streams partial-sum beats from the compute array into the accumulator,
// then requests readout and reports completion of the tile job.
module tc_psum_issue
    import tc_psum_issue_pkg::*;
#(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int TILE_M  = 4,
    parameter int K_STEPS = 4,
    parameter int DW_DATA = 8,
    parameter int DW_POS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [TILE_M*DW_DATA-1:0]   s_data,
    output logic [DW_POS-1:0]           psum_row,
    output logic [DW_POS-1:0]           psum_col,
    output logic [TILE_M*DW_DATA-1:0]   psum_in,
    output logic                        psum_input_en,
    output logic                        psum_out_en,
    input  logic                        psum_out_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int DW = TILE_M * DW_DATA;

    psum_state_e state_r;
    logic        arm_cnt_r;
    logic        seen_valid_r;
    logic        s_ready_r;
    logic        input_en_r;
    logic        out_en_r;
    logic        busy_r;
    logic        done_r;

    logic              xfer;
    logic              addr_last;
    logic [DW_POS-1:0] addr_row;
    logic [DW_POS-1:0] addr_col;

    // A beat moves only while the issue window is open and reset is low.
    assign xfer = s_ready_r & s_valid & ~rst;

    tc_tile_addr_gen #(
        .M       (M),
        .N       (N),
        .TILE_M  (TILE_M),
        .K_STEPS (K_STEPS),
        .DW_POS  (DW_POS)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_r == ST_IDLE),
        .advance (xfer),
        .row     (addr_row),
        .col     (addr_col),
        .last    (addr_last)
    );

    // Job sequencer; output flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            arm_cnt_r    <= 1'b0;
            seen_valid_r <= 1'b0;
            s_ready_r    <= 1'b0;
            input_en_r   <= 1'b0;
            out_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            out_en_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_ARM;
                        arm_cnt_r  <= 1'b0;
                        input_en_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (arm_cnt_r == 1'(ARM_CYCLES - 1)) begin
                        state_r   <= ST_ISSUE;
                        s_ready_r <= 1'b1;
                    end else begin
                        arm_cnt_r <= arm_cnt_r + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (xfer && addr_last) begin
                        state_r    <= ST_OUT_REQ;
                        s_ready_r  <= 1'b0;
                        input_en_r <= 1'b0;
                        out_en_r   <= 1'b1;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_OUT_REQ: begin
                    state_r      <= ST_WAIT_OUT;
                    seen_valid_r <= 1'b0;
                end
                ST_WAIT_OUT: begin
                    if (!seen_valid_r) begin
                        seen_valid_r <= psum_out_valid;
                    end else if (!psum_out_valid) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT_OUT;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    s_ready_r  <= 1'b0;
                    input_en_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Outputs read quiet while reset is held, even before the edge lands.
    assign s_ready       = s_ready_r  & ~rst;
    assign psum_input_en = input_en_r & ~rst;
    assign psum_out_en   = out_en_r   & ~rst;
    assign busy          = busy_r     & ~rst;
    assign done          = done_r     & ~rst;
    assign psum_row      = rst ? {DW_POS{1'b0}} : addr_row;
    assign psum_col      = rst ? {DW_POS{1'b0}} : addr_col;
    // The accumulator sums its input every cycle, so non-transfer cycles feed zero.
    assign psum_in       = xfer ? s_data : {DW{1'b0}};

endmodule

// File: tb/tb_tc_psum_issue.sv
// Directed + randomized bench for tc_psum_issue with a beat-index address model.
module tb_tc_psum_issue;

    localparam int M       = 8;
    localparam int N       = 2;
    localparam int TILE_M  = 4;
    localparam int K_STEPS = 2;
    localparam int DW_DATA = 8;
    localparam int DW_POS  = 4;
    localparam int BEATS   = K_STEPS * N * (M / TILE_M);

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  psum_row;
    logic [3:0]  psum_col;
    logic [31:0] psum_in;
    logic        psum_input_en;
    logic        psum_out_en;
    logic        psum_out_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    tc_psum_issue #(
        .M(M), .N(N), .TILE_M(TILE_M), .K_STEPS(K_STEPS),
        .DW_DATA(DW_DATA), .DW_POS(DW_POS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .psum_row       (psum_row),
        .psum_col       (psum_col),
        .psum_in        (psum_in),
        .psum_input_en  (psum_input_en),
        .psum_out_en    (psum_out_en),
        .psum_out_valid (psum_out_valid),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference addressing: beat b covers row group b mod (M/TILE_M), column next.
    function automatic logic [31:0] exp_row(input int b);
        return 32'((b % (M / TILE_M)) * TILE_M);
    endfunction

    function automatic logic [31:0] exp_col(input int b);
        return 32'((b / (M / TILE_M)) % N);
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_in_en"}, 32'(psum_input_en), 32'd0);
        chk({tag, "_out_en"}, 32'(psum_out_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_row"}, 32'(psum_row), 32'd0);
        chk({tag, "_col"}, 32'(psum_col), 32'd0);
        chk({tag, "_psum_in"}, psum_in, 32'd0);
    endtask

    // mode 0: s_valid held high, 1: toggling with 0x01010101, 2: random valid.
    task automatic run_job(input int mode, input bit st_issue, input bit st_fin, input int abort_at);
        int          b;
        int          cyc;
        bit          v;
        logic [31:0] d;
        // IDLE with s_valid high must not consume anything.
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        start   = 1'b1;
        #1;
        chk("idle_ready", 32'(s_ready), 32'd0);
        chk("idle_psum_in", psum_in, 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        step();
        start   = 1'b0;
        s_valid = 1'b0;
        for (int a = 0; a < 2; a++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            #1;
            chk("arm_in_en", 32'(psum_input_en), 32'd1);
            chk("arm_psum_in", psum_in, 32'd0);
            chk("arm_ready", 32'(s_ready), 32'd0);
            chk("arm_busy", 32'(busy), 32'd1);
            step();
        end
        b   = 0;
        cyc = 0;
        while (b < BEATS && cyc < 64) begin
            if (abort_at > 0 && b == abort_at) begin
                rst     = 1'b1;
                s_valid = 1'b1;
                s_data  = $urandom;
                #1;
                chk_quiet("in_rst");
                step();
                rst     = 1'b0;
                s_valid = 1'b0;
                #1;
                chk_quiet("post_rst");
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("abort_done", 32'(done), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                end
                return;
            end
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            d       = (mode == 1) ? 32'h01010101 : $urandom;
            s_valid = v;
            s_data  = d;
            start   = st_issue && (cyc == 3);
            #1;
            chk("issue_ready", 32'(s_ready), 32'd1);
            chk("issue_in_en", 32'(psum_input_en), 32'd1);
            chk($sformatf("psum_in_b%0d", b), psum_in, v ? d : 32'd0);
            chk($sformatf("row_b%0d", b), 32'(psum_row), exp_row(b));
            chk($sformatf("col_b%0d", b), 32'(psum_col), exp_col(b));
            chk("issue_out_en", 32'(psum_out_en), 32'd0);
            if (v) b++;
            cyc++;
            step();
        end
        chk("beats_in_budget", 32'(b), 32'(BEATS));
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = $urandom;
        #1;
        chk("out_req_pulse", 32'(psum_out_en), 32'd1);
        chk("out_req_ready", 32'(s_ready), 32'd0);
        chk("out_req_psum_in", psum_in, 32'd0);
        step();
        for (int i = 0; i < 9; i++) begin
            psum_out_valid = 1'b1;
            #1;
            chk("wait_done", 32'(done), 32'd0);
            chk("wait_out_en", 32'(psum_out_en), 32'd0);
            chk("wait_ready", 32'(s_ready), 32'd0);
            chk("wait_psum_in", psum_in, 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            step();
        end
        psum_out_valid = 1'b0;
        s_valid        = 1'b0;
        #1;
        chk("fall_done", 32'(done), 32'd0);
        step();
        start = st_fin;
        #1;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd1);
        step();
        start = 1'b0;
        #1;
        chk("after_done", 32'(done), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_in_en", 32'(psum_input_en), 32'd0);
        step();
        chk("idle2_busy", 32'(busy), 32'd0);
        chk("idle2_done", 32'(done), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        s_valid        = 1'b0;
        s_data         = 32'd0;
        psum_out_valid = 1'b0;
        step();
        step();
        chk_quiet("reset");
        rst = 1'b0;
        step();
        chk_quiet("idle");
        run_job(0, 1'b0, 1'b0, 0);
        run_job(1, 1'b0, 1'b0, 0);
        run_job(2, 1'b1, 1'b1, 0);
        run_job(0, 1'b0, 1'b0, 5);
        run_job(2, 1'b0, 1'b0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tc_psum_issue.md
TC_PSUM_ISSUE -- requirements
Module: tc_psum_issue

Interface
REQ-001 SHALL have parameters: M=16 (output rows); N=16 (output cols); TILE_M=4 (rows per beat, divides M); K_STEPS=4 (accumulation passes); DW_DATA=8; DW_POS=4 (row/col address width).
REQ-002 SHALL have ports clk in 1 (clock) and rst in 1 (reset, synchronous, active-high).
REQ-003 SHALL have start in 1: begin one tile job; sampled only in IDLE.
REQ-004 SHALL have s_valid in 1, s_ready out 1, s_data in TILE_M*DW_DATA: partial-sum beat from the compute array; lane i at bits [i*DW_DATA +: DW_DATA].
REQ-005 SHALL have psum_row out DW_POS, psum_col out DW_POS, psum_in out TILE_M*DW_DATA, psum_input_en out 1, psum_out_en out 1: these drive the accumulator.
REQ-006 SHALL have psum_out_valid in 1 (accumulator readout valid), busy out 1, done out 1.

Function
REQ-007 SHALL implement FSM states IDLE, ARM, ISSUE, OUT_REQ, WAIT_OUT, FIN.
REQ-008 IDLE: start=1 -> ARM; clears row-group, col and k counters.
REQ-009 ARM: SHALL last exactly 2 cycles with psum_input_en=1 and psum_in=0, covering the accumulator's 2-cycle state lag; then -> ISSUE.
REQ-010 ISSUE: s_ready=1; a beat transfers on s_valid&&s_ready.
REQ-011 psum_in SHALL equal s_data on a transfer cycle and all-zero on every other cycle, because the accumulator adds its input every cycle unconditionally.
REQ-012 psum_row = rg*TILE_M and psum_col = c, combinational from counters, valid in the same cycle as psum_in.
REQ-013 Walk order per transfer: rg increments first (0..M/TILE_M-1), then c (0..N-1), then k (0..K_STEPS-1), each wrapping to 0.
REQ-014 Total beats per job = K_STEPS*N*(M/TILE_M); the transfer of the last beat -> OUT_REQ.
REQ-015 OUT_REQ: psum_out_en=1 for exactly 1 cycle; -> WAIT_OUT.
REQ-016 WAIT_OUT: wait for psum_out_valid=1, then for psum_out_valid=0; -> FIN.
REQ-017 FIN: done=1 for exactly 1 cycle; -> IDLE.
REQ-018 busy=1 in every state except IDLE.
REQ-019 s_ready=0 outside ISSUE; s_valid outside ISSUE SHALL be ignored and not consumed.
REQ-020 start outside IDLE SHALL be ignored; start in FIN SHALL NOT be accepted until the next cycle (IDLE).
REQ-021 s_valid deasserted mid-ISSUE: counters hold, psum_in=0, and no address advances.
REQ-022 Counter widths SHALL hold their maximum values without overflow; address arithmetic SHALL truncate to DW_POS.

Reset
REQ-023 rst SHALL force IDLE and clear all counters at the next clk edge, including mid-job.
REQ-024 During and after reset: s_ready, psum_input_en, psum_out_en, busy, done, psum_row, psum_col and psum_in SHALL all be 0.
REQ-025 A job interrupted by reset SHALL NOT assert done.

Structure
REQ-026 The FSM state encoding and the beat-count derivation K_STEPS*N*(M/TILE_M) SHALL live in the shared tensor-core package.
REQ-027 A sub-module tc_tile_addr_gen (rg/c/k nested counter with advance input and last flag) is natural and SHALL be used.

Verification
Bench parameters: M=8, N=2, TILE_M=4, K_STEPS=2, giving 8 beats per job.
REQ-028 start, then s_valid held high -> psum_input_en high for 2 cycles, then 8 transfers with (row,col) sequence (0,0),(4,0),(0,1),(4,1) repeated twice -> psum_out_en one-cycle pulse.
REQ-029 s_valid toggled 1/0 each cycle with s_data=0x01010101 -> psum_in=0 on idle cycles, addresses advance only on transfers, still 8 transfers total.
REQ-030 After OUT_REQ, drive psum_out_valid high 9 cycles then low -> done pulses exactly once, 1 cycle after the fall; busy=0 on the following cycle.
REQ-031 rst asserted after the 5th transfer -> next cycle all outputs 0, state IDLE, no done; a new start restarts at (0,0).
REQ-032 start pulsed during ISSUE and during FIN -> ignored, with a single job completing.
REQ-033 s_valid high while in IDLE or WAIT_OUT -> s_ready=0 and no psum_in activity.
